// File: rtl/ped_signal_controller_pkg.sv
// ---------------------------------------------------------------------------
// ped_pkg
// Shared definitions for the pedestrian signal controller:
//   - lamp encodings driven by the upstream traffic_light_controller
//   - per-crossing FSM state enum
//   - lamp_valid(): true only for the three legal one-hot lamp codes
// ---------------------------------------------------------------------------
package ped_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2
  } ped_state_t;

  function automatic logic lamp_valid(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_YELLOW) || (lamp == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/ped_signal_controller_if.sv
// ---------------------------------------------------------------------------
// ped_signal_controller_if
// Bundles the lamp inputs, push buttons and pedestrian head outputs.
//   master : the environment (traffic controller + buttons), drives lamps and
//            buttons, observes the heads and fault flag
//   slave  : ped_signal_controller
// Signals:
//   ns, ew          3-bit lamp codes (RED/YELLOW/GREEN)
//   btn_ns, btn_ew  level push buttons, synchronous to clk
//   walk_*          WALK heads
//   dontwalk_*      DONT_WALK heads
//   fault           sticky conflict / invalid-lamp flag
// ---------------------------------------------------------------------------
interface ped_signal_controller_if;

  logic [2:0] ns;
  logic [2:0] ew;
  logic       btn_ns;
  logic       btn_ew;
  logic       walk_ns;
  logic       dontwalk_ns;
  logic       walk_ew;
  logic       dontwalk_ew;
  logic       fault;

  modport master (
    output ns, ew, btn_ns, btn_ew,
    input  walk_ns, dontwalk_ns, walk_ew, dontwalk_ew, fault
  );

  modport slave (
    input  ns, ew, btn_ns, btn_ew,
    output walk_ns, dontwalk_ns, walk_ew, dontwalk_ew, fault
  );

endinterface

// File: rtl/ped_signal_controller_crossing_fsm.sv
// ---------------------------------------------------------------------------
// ped_crossing_fsm
// One crosswalk: request latch, green-onset detect, phase counter and the
// IDLE -> WALK -> FLASH -> IDLE sequencer. Heads are registered.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   lamp         lamp of the traffic direction this crossing walks alongside
//   btn          push button (level)
//   force_idle   hold in IDLE, drop the request, ignore the button
//   walk         WALK head
//   dontwalk     DONT_WALK head (solid in IDLE, toggling in FLASH)
// ---------------------------------------------------------------------------
module ped_crossing_fsm
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 4,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  input  logic       btn,
  input  logic       force_idle,
  output logic       walk,
  output logic       dontwalk
);

  // Counter runs 0..N-1 inside a phase; the last value triggers the exit.
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             prev_green_q;
  logic             walk_d, dontwalk_d;
  logic             is_green, onset;

  assign is_green = (lamp == LAMP_GREEN);
  assign onset    = is_green && !prev_green_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Presses while walking are dropped; otherwise they stick until granted.
    req_d   = req_q || (btn && (state_q != WALK));

    unique case (state_q)
      IDLE: begin
        // A press in the onset cycle itself counts as a request.
        if (onset && (req_q || btn)) begin
          state_d = WALK;
          cnt_d   = '0;
          req_d   = 1'b0;
        end
      end
      WALK: begin
        // Leave on timeout, or as soon as the lamp stops being green.
        if ((cnt_q == WALK_LAST) || !is_green) begin
          state_d = FLASH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLASH: begin
        // Clearance always runs to completion, independent of the lamp.
        if (cnt_q == FLASH_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (force_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
    end

    // Heads are decoded from the next state so they change on the same edge.
    walk_d = (state_d == WALK);
    unique case (state_d)
      WALK:    dontwalk_d = 1'b0;
      // First FLASH cycle shows 0, then toggles each cycle.
      FLASH:   dontwalk_d = (state_q == FLASH) ? !dontwalk : 1'b0;
      default: dontwalk_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      prev_green_q <= 1'b0;
      walk         <= 1'b0;
      dontwalk     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      prev_green_q <= is_green;
      walk         <= walk_d;
      dontwalk     <= dontwalk_d;
    end
  end

endmodule

// File: rtl/ped_signal_controller.sv
// ---------------------------------------------------------------------------
// ped_signal_controller
// Pedestrian heads for the NS and EW crosswalks, driven from the traffic
// lamps, plus a sticky safety monitor that forces all heads to solid
// DONT_WALK on any conflicting or invalid lamp pattern.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   ped_signal_controller_if.slave: lamps and buttons in, heads and
//         fault out (all outputs registered)
// ---------------------------------------------------------------------------
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 4,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ped_signal_controller_if.slave  bus
);

  logic bad_lamps;
  logic fault_q;
  logic force_idle;
  logic walk_ns, dontwalk_ns, walk_ew, dontwalk_ew;

  // Unsafe: neither direction is red, or either lamp code is illegal.
  assign bad_lamps = ((bus.ns != LAMP_RED) && (bus.ew != LAMP_RED)) ||
                     !lamp_valid(bus.ns) || !lamp_valid(bus.ew);

  // Include the live detection so the heads go safe on the same edge that
  // raises fault, pre-empting any FSM transition sampled in the bad cycle.
  assign force_idle = fault_q || bad_lamps;

  // NOTE: only control state is reset; there is no storage array here that
  // would need a clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (bad_lamps) begin
      fault_q <= 1'b1;
    end
  end

  ped_crossing_fsm #(
    .WALK_CYCLES (WALK_CYCLES),
    .FLASH_CYCLES(FLASH_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ns (
    .clk       (clk),
    .rst       (rst),
    .lamp      (bus.ns),
    .btn       (bus.btn_ns),
    .force_idle(force_idle),
    .walk      (walk_ns),
    .dontwalk  (dontwalk_ns)
  );

  ped_crossing_fsm #(
    .WALK_CYCLES (WALK_CYCLES),
    .FLASH_CYCLES(FLASH_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ew (
    .clk       (clk),
    .rst       (rst),
    .lamp      (bus.ew),
    .btn       (bus.btn_ew),
    .force_idle(force_idle),
    .walk      (walk_ew),
    .dontwalk  (dontwalk_ew)
  );

  assign bus.walk_ns     = walk_ns;
  assign bus.dontwalk_ns = dontwalk_ns;
  assign bus.walk_ew     = walk_ew;
  assign bus.dontwalk_ew = dontwalk_ew;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// ---------------------------------------------------------------------------
// tb_ped_signal_controller
// Directed stimulus with hand-computed head values. Each stimulus cycle
// pushes the outputs expected after that clock edge into a queue; a separate
// monitor pops one entry per falling edge and compares.
// Expected vector bit order: {walk_ns, dontwalk_ns, walk_ew, dontwalk_ew, fault}
// ---------------------------------------------------------------------------
module tb_ped_signal_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] X = 3'b000;

  localparam logic [4:0] IDL  = 5'b01010;  // both solid DONT_WALK
  localparam logic [4:0] NSW  = 5'b10010;  // NS WALK
  localparam logic [4:0] NSF0 = 5'b00010;  // NS flash, dark phase
  localparam logic [4:0] EWW  = 5'b01100;  // EW WALK
  localparam logic [4:0] EWF0 = 5'b01000;  // EW flash, dark phase
  localparam logic [4:0] FLT  = 5'b01011;  // safe heads, fault set

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  ped_signal_controller_if bus ();

  ped_signal_controller #(
    .WALK_CYCLES (4),
    .FLASH_CYCLES(4),
    .CNT_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b ({walk_ns,dontwalk_ns,walk_ew,dontwalk_ew,fault})",
               name, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, {bus.walk_ns, bus.dontwalk_ns, bus.walk_ew, bus.dontwalk_ew, bus.fault},
            e.exp);
    end
  end

  // One clock of stimulus; exp is what the heads show after this edge.
  task automatic cyc(input logic r, input logic [2:0] n, input logic [2:0] e,
                     input logic bn, input logic be, input logic [4:0] exp,
                     input string name);
    exp_t ent;
    rst        = r;
    bus.ns     = n;
    bus.ew     = e;
    bus.btn_ns = bn;
    bus.btn_ew = be;
    @(posedge clk);
    #1;
    ent.exp  = exp;
    ent.name = name;
    sb.push_back(ent);
  endtask

  initial begin
    rst = 1'b1; bus.ns = G; bus.ew = R; bus.btn_ns = 1'b0; bus.btn_ew = 1'b0;

    // Reset with NS green
    cyc(1, G, R, 0, 0, IDL, "reset0");
    cyc(1, G, R, 0, 0, IDL, "reset1");

    // Basic NS grant: onset at T, WALK T+1..T+4, flash 0,1,0,1, then solid
    cyc(0, R, G, 1, 0, IDL, "basic_press");
    cyc(0, R, G, 0, 0, IDL, "basic_wait");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, NSW, "basic_walk");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, i[0] ? IDL : NSF0, "basic_flash");
    cyc(0, G, R, 0, 0, IDL, "basic_done");
    cyc(0, Y, R, 0, 0, IDL, "basic_done2");

    // Early abort on yellow at T+2
    cyc(0, R, G, 1, 0, IDL,  "abort_press");
    cyc(0, G, R, 0, 0, NSW,  "abort_walk");
    cyc(0, G, R, 0, 0, NSW,  "abort_walk");
    cyc(0, Y, R, 0, 0, NSF0, "abort_flash0");
    cyc(0, Y, R, 0, 0, IDL,  "abort_flash1");
    cyc(0, R, R, 0, 0, NSF0, "abort_flash2");
    cyc(0, R, R, 0, 0, IDL,  "abort_flash3");
    cyc(0, R, R, 0, 0, IDL,  "abort_done");

    // Onsets without any request
    cyc(0, R, G, 0, 0, IDL, "noreq_ew_onset");
    cyc(0, R, G, 0, 0, IDL, "noreq");
    for (int i = 0; i < 3; i++) cyc(0, G, R, 0, 0, IDL, "noreq_ns_onset");

    // Press during WALK is ignored
    cyc(0, R, G, 1, 0, IDL, "pw_press");
    cyc(0, G, R, 0, 0, NSW, "pw_walk");
    cyc(0, G, R, 1, 0, NSW, "pw_walk_btn");
    cyc(0, G, R, 1, 0, NSW, "pw_walk_btn");
    cyc(0, G, R, 0, 0, NSW, "pw_walk");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, i[0] ? IDL : NSF0, "pw_flash");
    cyc(0, G, R, 0, 0, IDL, "pw_done");
    cyc(0, R, G, 0, 0, IDL, "pw_ew_green");
    cyc(0, G, R, 0, 0, IDL, "pw_no_regrant");
    cyc(0, G, R, 0, 0, IDL, "pw_no_regrant");

    // Press during FLASH is held to the next onset
    cyc(0, R, G, 1, 0, IDL, "pf_press");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, NSW, "pf_walk");
    cyc(0, G, R, 0, 0, NSF0, "pf_flash0");
    cyc(0, G, R, 1, 0, IDL,  "pf_flash1_btn");
    cyc(0, G, R, 0, 0, NSF0, "pf_flash2");
    cyc(0, G, R, 0, 0, IDL,  "pf_flash3");
    cyc(0, G, R, 0, 0, IDL,  "pf_idle");
    cyc(0, R, G, 0, 0, IDL,  "pf_ew_green");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, NSW, "pf_regrant");
    for (int i = 0; i < 4; i++) cyc(0, G, R, 0, 0, i[0] ? IDL : NSF0, "pf_reflash");
    cyc(0, G, R, 0, 0, IDL, "pf_done");

    // EW grant with the button pressed in the onset cycle itself
    cyc(0, Y, R, 0, 0, IDL, "ew_prep");
    cyc(0, R, R, 0, 0, IDL, "ew_prep");
    cyc(0, R, G, 0, 1, EWW, "ew_same_cycle");
    for (int i = 0; i < 3; i++) cyc(0, R, G, 0, 0, EWW, "ew_walk");
    for (int i = 0; i < 4; i++) cyc(0, R, G, 0, 0, i[0] ? IDL : EWF0, "ew_flash");
    cyc(0, R, G, 0, 0, IDL, "ew_done");

    // Reset mid-WALK drops the request and the onset memory
    cyc(0, R, G, 1, 0, IDL, "rw_press");
    cyc(0, G, R, 0, 0, NSW, "rw_walk");
    cyc(1, G, R, 0, 0, IDL, "rw_rst");
    cyc(0, G, R, 0, 0, IDL, "rw_after_rst");

    // Conflict during NS WALK: sticky fault, buttons ignored, until rst
    cyc(0, R, G, 1, 0, IDL, "cf_press");
    cyc(0, G, R, 0, 0, NSW, "cf_walk");
    cyc(0, G, G, 0, 0, FLT, "cf_conflict");
    cyc(0, G, R, 0, 0, FLT, "cf_sticky");
    cyc(0, G, R, 1, 0, FLT, "cf_btn_ignored");
    cyc(0, R, G, 1, 1, FLT, "cf_btn_ignored");
    cyc(0, G, R, 0, 0, FLT, "cf_sticky_onset");
    cyc(1, G, R, 0, 0, IDL, "cf_rst");

    // Invalid lamp code
    cyc(0, R, G, 0, 0, IDL, "inv_prep");
    cyc(0, X, R, 0, 0, FLT, "inv_fault");
    cyc(0, R, G, 0, 0, FLT, "inv_sticky");
    cyc(1, R, G, 0, 0, IDL, "inv_rst");
    cyc(0, R, G, 0, 0, IDL, "inv_clear");

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_signal_controller.md
Name: ped_signal_controller

Overview:
- Downstream consumer of the traffic_light_controller lamp outputs (ns, ew).
- Drives pedestrian WALK / DONT_WALK heads for two crosswalks:
  - Crossing NS: pedestrians walk alongside NS traffic, during NS green.
  - Crossing EW: pedestrians walk alongside EW traffic, during EW green.
- Latches push-button requests, grants a timed WALK at the next green onset, then a flashing DONT_WALK clearance.
- Acts as a safety monitor: any conflicting or invalid lamp pattern forces all heads to solid DONT_WALK.

Parameters:
- WALK_CYCLES, 4, clock cycles WALK is held (1..255).
- FLASH_CYCLES, 4, clock cycles of flashing DONT_WALK clearance (1..255).
- CNT_W, 8, width of the internal phase counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ns  input  3  NS lamp from traffic_light_controller.
- ew  input  3  EW lamp from traffic_light_controller.
- btn_ns  input  1  crossing-NS push button, level, synchronous to clk.
- btn_ew  input  1  crossing-EW push button, level, synchronous to clk.
- walk_ns  output  1  crossing-NS WALK head.
- dontwalk_ns  output  1  crossing-NS DONT_WALK head.
- walk_ew  output  1  crossing-EW WALK head.
- dontwalk_ew  output  1  crossing-EW DONT_WALK head.
- fault  output  1  sticky conflict/invalid-lamp flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Lamp encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001. Any other value is invalid.
- Reset values:
  - walk_*=0, dontwalk_*=1, fault=0.
  - Request latches=0, FSMs=IDLE, counters=0, prev_green_*=0.
- Request latch (per crossing):
  - Set when btn high in any cycle except while in WALK; presses during WALK are ignored.
  - Cleared on entry to WALK.
  - Presses during FLASH or IDLE are held until the next green onset.
- Green onset (per crossing): lamp==GREEN && prev_green==0. prev_green is the registered (lamp==GREEN).
- FSM per crossing:
  - IDLE: walk=0, dontwalk=1 solid.
    - To WALK when green onset && (req || btn in that same cycle).
    - walk rises on the clock edge that samples the onset: registered, visible the cycle after onset.
  - WALK: walk=1, dontwalk=0, counter counts WALK_CYCLES.
    - To FLASH after exactly WALK_CYCLES cycles.
    - To FLASH early on the first cycle the lamp is no longer GREEN (yellow/red abort).
  - FLASH: walk=0, dontwalk toggles every cycle, starting at 0 on the first FLASH cycle.
    - Lasts exactly FLASH_CYCLES cycles regardless of lamp state, then IDLE with dontwalk=1.
  - A green onset while in WALK or FLASH does not restart; a latched request waits for the following onset.
- Fault detection:
  - fault sets when both ns!=RED and ew!=RED in the same cycle, or when either lamp is invalid.
  - Registered; asserted the cycle after the bad sample.
  - Sticky until rst.
  - While fault=1: both FSMs held in IDLE, requests cleared, buttons ignored, walk_*=0, dontwalk_*=1 solid.
- Simultaneous events:
  - Fault detection has priority over any transition in the same cycle.
  - rst has priority over everything.
  - rst mid-WALK/FLASH returns to reset values on the next edge.
- Counter width: compare against the parameter; no wrap, since CNT_W covers 255.

Decomposition:
- Shared package ped_pkg holds:
  - Lamp constants LAMP_RED/LAMP_YELLOW/LAMP_GREEN.
  - FSM state enum IDLE/WALK/FLASH (2 bits).
- One sub-module, ped_crossing_fsm, instantiated twice (NS, EW). It contains the request latch, onset detect, counter and FSM.
- The top holds the fault monitor and feeds each FSM lamp, btn and force_idle (=fault).

Test Plan:
- Reset: rst=1 for 2 cycles with ns=GREEN, ew=RED -> walk_*=0, dontwalk_*=1, fault=0.
- Basic grant: ns=RED, ew=GREEN; pulse btn_ns 1 cycle; ns goes GREEN, ew RED at cycle T.
  - walk_ns=1 for cycles T+1..T+4.
  - dontwalk_ns = 0,1,0,1 on T+5..T+8.
  - dontwalk_ns=1 solid from T+9; walk_ew stays 0.
- Early abort: same as the basic grant, but ns goes YELLOW at T+2 -> walk_ns=1 only on T+1..T+2, FLASH on T+3..T+6.
- No request: green onsets with no button -> walk_* stay 0 throughout.
- Press during WALK: btn_ns high during WALK -> no second grant at the next NS onset. Press during FLASH -> grant at the next onset.
- Conflict: ns=GREEN, ew=GREEN for 1 cycle during WALK -> fault=1 next cycle; walk_ns=0, dontwalk_ns=1. These persist after the lamps return to normal, until rst. Same fault response for ns=3'b000.
